fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_hold_buf.sv | 42 ++++
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int          INSTR_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_hold_buf.sv
// One-entry skid register that keeps a fetched {pc, instr} while decode is stalled.
module fetch_hold_buf
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = 64,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_pop,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_full,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr
);

    logic               r_full;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_full  <= 1'b0;
            r_pc    <= '0;
            r_instr <= INSTR_W'(NOP_INSTR);
        end else if (i_clear || i_pop) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_full  = r_full;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// PC register, one-outstanding imem handshake and IF/ID register for the 5-stage core.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush performance counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               PC_write,
    input  logic               IF_ID_write,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    IF_ID_pc,
    output logic [INSTR_W-1:0] IF_ID_instr,
    output logic               IF_ID_valid,
    output logic               fetch_starve
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_count
`endif
);

    fetch_state_e       r_state, w_state_nxt;
    logic [PC_W-1:0]    r_pc, w_pc_nxt;
    logic               r_live;
    logic [PC_W-1:0]    r_ifid_pc;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic               r_ifid_valid, r_starve;

    logic               w_advance, w_issue, w_have_instr;
    logic               w_buf_load, w_buf_clear, w_buf_pop, w_buf_full;
    logic [PC_W-1:0]    w_new_pc, w_buf_pc;
    logic [INSTR_W-1:0] w_new_instr, w_buf_instr;

    assign w_advance = PC_write && IF_ID_write;
    // No request while reset is asserted or on the very first edge after it.
    assign w_issue   = (r_state == ISSUE) && r_live;

    fetch_hold_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_hold (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_pop   (w_buf_pop),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .o_full  (w_buf_full),
        .o_pc    (w_buf_pc),
        .o_instr (w_buf_instr)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ISSUE;
            r_pc    <= RESET_PC;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_buf_load   = 1'b0;
        w_buf_clear  = 1'b0;
        w_buf_pop    = 1'b0;
        w_have_instr = 1'b0;
        w_new_pc     = r_pc;
        w_new_instr  = imem_rdata;
        case (r_state)
            ISSUE: begin
                if (branch_taken) w_pc_nxt = branch_target;
                // A request issued alongside a redirect is stale and must be drained.
                if (w_issue) w_state_nxt = branch_taken ? DRAIN : WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = ISSUE;
                    if (branch_taken) begin
                        w_pc_nxt = branch_target;
                    end else if (w_advance) begin
                        w_have_instr = 1'b1;
                        w_pc_nxt     = r_pc + PC_W'(4);
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_buf_clear = 1'b1;
                    w_pc_nxt    = branch_target;
                    w_state_nxt = ISSUE;
                end else if (w_advance && w_buf_full) begin
                    w_have_instr = 1'b1;
                    w_new_pc     = w_buf_pc;
                    w_new_instr  = w_buf_instr;
                    w_buf_pop    = 1'b1;
                    w_pc_nxt     = r_pc + PC_W'(4);
                    w_state_nxt  = ISSUE;
                end
            end
            DRAIN: begin
                if (branch_taken) w_pc_nxt = branch_target;
                if (imem_rvalid)  w_state_nxt = ISSUE;
            end
            default: w_state_nxt = ISSUE;
        endcase
    end

    // Flush beats load, load beats bubble, bubble beats hold.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= INSTR_W'(NOP_INSTR);
            r_ifid_valid <= 1'b0;
            r_starve     <= 1'b0;
        end else begin
            r_starve <= 1'b0;
            if (branch_taken) begin
                r_ifid_instr <= INSTR_W'(NOP_INSTR);
                r_ifid_valid <= 1'b0;
            end else if (IF_ID_write) begin
                if (w_have_instr) begin
                    r_ifid_pc    <= w_new_pc;
                    r_ifid_instr <= w_new_instr;
                    r_ifid_valid <= 1'b1;
                end else begin
                    r_ifid_instr <= INSTR_W'(NOP_INSTR);
                    r_ifid_valid <= 1'b0;
                    r_starve     <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_stall, r_perf_flush;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (!w_advance && r_ifid_valid && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (branch_taken && (r_perf_flush != '1))
                r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_count  = r_perf_flush;
`endif

    assign imem_req     = w_issue;
    assign imem_addr    = r_pc;
    assign IF_ID_pc     = r_ifid_pc;
    assign IF_ID_instr  = r_ifid_instr;
    assign IF_ID_valid  = r_ifid_valid;
    assign fetch_starve = r_starve;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle table plus randomized run against an in-order fetch-stream model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        PC_write, IF_ID_write, branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic        fetch_starve;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    fetch_unit dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .PC_write      (PC_write),
        .IF_ID_write   (IF_ID_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid),
        .fetch_starve  (fetch_starve)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcw, ifw, br;
        logic [63:0] tgt;
        logic        rv;
        logic [31:0] rd;
        logic        ereq;
        logic [63:0] eaddr;
        logic [63:0] epc;
        logic [31:0] einstr;
        logic        evld, estv;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h0010_0093;
        if (a == 64'h4) return 32'h0020_0113;
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic add(input int pcw, input int ifw, input int br, input logic [63:0] tgt,
                       input int rv, input logic [31:0] rd, input int ereq,
                       input logic [63:0] eaddr, input logic [63:0] epc,
                       input logic [31:0] ein, input int evld, input int estv);
        vec_t v;
        v.pcw = 1'(pcw); v.ifw = 1'(ifw); v.br = 1'(br); v.tgt = tgt;
        v.rv = 1'(rv); v.rd = rd; v.ereq = 1'(ereq); v.eaddr = eaddr;
        v.epc = epc; v.einstr = ein; v.evld = 1'(evld); v.estv = 1'(estv);
        tbl.push_back(v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},    64'(imem_req), 64'd0);
        chk({tag, "_addr"},   imem_addr, 64'd0);
        chk({tag, "_pc"},     IF_ID_pc, 64'd0);
        chk({tag, "_instr"},  64'(IF_ID_instr), 64'(NOP));
        chk({tag, "_valid"},  64'(IF_ID_valid), 64'd0);
        chk({tag, "_starve"}, 64'(fetch_starve), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_perf_stall"}, 64'(perf_stall_cycles), 64'd0);
        chk({tag, "_perf_flush"}, 64'(perf_flush_count), 64'd0);
`endif
    endtask

    // random-phase state
    logic [63:0] exp_pc, oaddr, s_addr, p_pc, p_tgt;
    logic [31:0] p_instr;
    logic        outst, rv, s_req, p_valid, p_ifw, p_br;
    int          wcnt, delivered;

    initial begin
        arst_n = 1'b0; PC_write = 1'b0; IF_ID_write = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_rvalid = 1'b0; imem_rdata = '0;

        // pcw ifw br tgt  rv rd  ereq eaddr  epc  einstr evld estv
        add(1,1,0,0,      0,0,              1,64'h0,   64'h0,  NOP,              0,1);
        add(1,1,0,0,      1,32'h0010_0093,  0,0,       64'h0,  32'h0010_0093,    1,0);
        add(1,1,0,0,      0,0,              1,64'h4,   64'h0,  NOP,              0,1);
        add(1,1,0,0,      1,32'h0020_0113,  0,0,       64'h4,  32'h0020_0113,    1,0);
        add(0,0,0,0,      0,0,              1,64'h8,   64'h4,  32'h0020_0113,    1,0);
        add(0,0,0,0,      1,mem_word(64'h8),0,0,       64'h4,  32'h0020_0113,    1,0);
        add(0,0,0,0,      0,0,              0,0,       64'h4,  32'h0020_0113,    1,0);
        add(0,0,0,0,      0,0,              0,0,       64'h4,  32'h0020_0113,    1,0);
        add(1,1,0,0,      0,0,              0,0,       64'h8,  mem_word(64'h8),  1,0);
        add(1,1,0,0,      0,0,              1,64'hC,   64'h8,  NOP,              0,1);
        add(1,1,1,64'h100,0,0,              0,0,       64'h8,  NOP,              0,0);
        add(1,1,0,0,      0,0,              0,0,       64'h8,  NOP,              0,1);
        add(1,1,0,0,      0,0,              0,0,       64'h8,  NOP,              0,1);
        add(1,1,0,0,      1,mem_word(64'hC),0,0,       64'h8,  NOP,              0,1);
        add(1,1,0,0,      0,0,              1,64'h100, 64'h8,  NOP,              0,1);
        add(1,1,1,64'h200,1,mem_word(64'h100),0,0,     64'h8,  NOP,              0,0);
        add(1,1,0,0,      0,0,              1,64'h200, 64'h8,  NOP,              0,1);
        add(1,1,0,0,      0,0,              0,0,       64'h8,  NOP,              0,1);
        add(1,1,0,0,      0,0,              0,0,       64'h8,  NOP,              0,1);
        add(1,1,0,0,      1,mem_word(64'h200),0,0,     64'h200,mem_word(64'h200),1,0);
        add(0,0,0,0,      0,0,              1,64'h204, 64'h200,mem_word(64'h200),1,0);

        @(posedge clk); @(posedge clk); #1;
        chk_reset_vals("reset");
        #1 arst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            PC_write = tbl[i].pcw; IF_ID_write = tbl[i].ifw;
            branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
            imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd;
            chk($sformatf("row%0d_req", i), 64'(imem_req), 64'(tbl[i].ereq));
            if (tbl[i].ereq) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
            @(posedge clk); #1;
            chk($sformatf("row%0d_pc", i),     IF_ID_pc, tbl[i].epc);
            chk($sformatf("row%0d_instr", i),  64'(IF_ID_instr), 64'(tbl[i].einstr));
            chk($sformatf("row%0d_valid", i),  64'(IF_ID_valid), 64'(tbl[i].evld));
            chk($sformatf("row%0d_starve", i), 64'(fetch_starve), 64'(tbl[i].estv));
        end

        // Reset pulse while a request is outstanding (state WAIT).
        PC_write = 1'b1; IF_ID_write = 1'b1; branch_taken = 1'b0; imem_rvalid = 1'b0;
        #2 arst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        #3 arst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_req",  64'(imem_req), 64'd1);
        chk("post_reset_addr", imem_addr, 64'd0);

        // Randomized run: every valid IF/ID load must continue the architectural PC stream.
        exp_pc = 64'h0; outst = 1'b0; delivered = 0; wcnt = 0; oaddr = '0;
        for (int t = 0; t < 1500; t++) begin
            rv = 1'b0;
            if (outst) begin
                if (wcnt == 0) rv = 1'b1;
                else wcnt--;
            end
            if (imem_req) chk("single_outstanding", 64'(outst), 64'd0);
            imem_rvalid   = rv;
            imem_rdata    = rv ? mem_word(oaddr) : $urandom;
            PC_write      = ($urandom_range(0, 3) != 0);
            IF_ID_write   = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = 64'($urandom_range(0, 1023)) << 2;
            s_req = imem_req; s_addr = imem_addr;
            p_pc = IF_ID_pc; p_instr = IF_ID_instr; p_valid = IF_ID_valid;
            p_ifw = IF_ID_write; p_br = branch_taken; p_tgt = branch_target;
            @(posedge clk); #1;
            if (rv) outst = 1'b0;
            if (s_req) begin
                outst = 1'b1; oaddr = s_addr; wcnt = $urandom_range(0, 3);
            end
            if (p_br) begin
                exp_pc = p_tgt;
                chk("rnd_flush_valid",  64'(IF_ID_valid), 64'd0);
                chk("rnd_flush_pc",     IF_ID_pc, p_pc);
                chk("rnd_flush_starve", 64'(fetch_starve), 64'd0);
            end else if (p_ifw) begin
                chk("rnd_starve", 64'(fetch_starve), 64'(!IF_ID_valid));
                if (IF_ID_valid) begin
                    chk("rnd_stream_pc",    IF_ID_pc, exp_pc);
                    chk("rnd_stream_instr", 64'(IF_ID_instr), 64'(mem_word(exp_pc)));
                    exp_pc = exp_pc + 64'd4;
                    delivered++;
                end else begin
                    chk("rnd_bubble_instr", 64'(IF_ID_instr), 64'(NOP));
                end
            end else begin
                chk("rnd_hold_pc",     IF_ID_pc, p_pc);
                chk("rnd_hold_instr",  64'(IF_ID_instr), 64'(p_instr));
                chk("rnd_hold_valid",  64'(IF_ID_valid), 64'(p_valid));
                chk("rnd_hold_starve", 64'(fetch_starve), 64'd0);
            end
        end
        chk("rnd_min_deliveries", 64'(delivered >= 50), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
